// File: rtl/timer_irq_scheduler_if.sv
// Interrupt request handshake between the scheduler and the CPU interrupt controller.
// The scheduler (master) raises irq_req with a stable irq_vec; the CPU (slave) answers with irq_ack.
interface timer_irq_scheduler_if #(
  parameter int VEC_WIDTH = 4
);

  logic                 irq_req;
  logic [VEC_WIDTH-1:0] irq_vec;
  logic                 irq_ack;

  modport master (
    output irq_req,
    output irq_vec,
    input  irq_ack
  );

  modport slave (
    input  irq_req,
    input  irq_vec,
    output irq_ack
  );

endinterface

// File: rtl/timer_irq_scheduler.sv
// Timer interrupt scheduler.
// Latches rising edges of the CMIA/CMIB/OVI lines of every timer channel into pending bits,
// then hands one enabled pending source at a time to the CPU, lowest index first.
// Source index i = 3*ch + k with k = 0 CMIA, 1 CMIB, 2 OVI.
module timer_irq_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int VEC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     i_cmia,
  input  logic [NUM_CH-1:0]     i_cmib,
  input  logic [NUM_CH-1:0]     i_ovi,
  input  logic [3*NUM_CH-1:0]   i_irq_en,
  input  logic                  i_clr_valid,
  input  logic [VEC_WIDTH-1:0]  i_clr_idx,
  output logic [3*NUM_CH-1:0]   o_pend,
  timer_irq_scheduler_if.master irqIf
);

  localparam int NSRC = 3 * NUM_CH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_req;
  logic [VEC_WIDTH-1:0]  r_vec;
  logic [VEC_WIDTH-1:0]  w_nextVec;
  logic [NSRC-1:0]       r_pend;
  logic [NSRC-1:0]       r_prevSrc;
  logic [NSRC-1:0]       w_src;
  logic [NSRC-1:0]       w_rise;
  logic [NSRC-1:0]       w_clr;
  logic [NSRC-1:0]       w_cand;
  logic                  w_anyCand;
  logic [VEC_WIDTH-1:0]  w_sel;
  logic                  w_ackClr;

  // Interleave the three per-channel source buses into one flat source vector.
  always_comb begin
    w_src = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_src[3*ch]     = i_cmia[ch];
      w_src[3*ch + 1] = i_cmib[ch];
      w_src[3*ch + 2] = i_ovi[ch];
    end
  end

  assign w_rise   = w_src & ~r_prevSrc;
  assign w_ackClr = (r_state == ST_REQ) && irqIf.irq_ack;

  // Build the clear mask from the acknowledged vector and the software strobe; out-of-range indices match nothing.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_ackClr && (r_vec == VEC_WIDTH'(i))) begin
        w_clr[i] = 1'b1;
      end
      if (i_clr_valid && (i_clr_idx == VEC_WIDTH'(i))) begin
        w_clr[i] = 1'b1;
      end
    end
  end

  // Edge history and pending flags; a fresh edge overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevSrc <= '0;
      r_pend    <= '0;
    end else begin
      r_prevSrc <= w_src;
      r_pend    <= (r_pend & ~w_clr) | w_rise;
    end
  end

  assign w_cand    = r_pend & i_irq_en;
  assign w_anyCand = |w_cand;

  // Fixed-priority pick: scan downwards so the lowest set index is the last one written.
  always_comb begin
    w_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_sel = VEC_WIDTH'(i);
      end
    end
  end

  // Next-state logic: request is held until acknowledged, then one forced low cycle before re-arbitrating.
  always_comb begin
    w_nextState = r_state;
    w_nextVec   = r_vec;
    case (r_state)
      ST_IDLE: begin
        if (w_anyCand) begin
          w_nextState = ST_REQ;
          w_nextVec   = w_sel;
        end
      end
      ST_REQ: begin
        if (irqIf.irq_ack) begin
          w_nextState = ST_GAP;
        end
      end
      ST_GAP: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register with registered request and vector outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_vec   <= '0;
    end else begin
      r_state <= w_nextState;
      r_req   <= (w_nextState == ST_REQ);
      r_vec   <= w_nextVec;
    end
  end

  assign irqIf.irq_req = r_req;
  assign irqIf.irq_vec = r_vec;
  assign o_pend        = r_pend;

endmodule

// File: tb/tb_timer_irq_scheduler.sv
// Self-checking bench for timer_irq_scheduler.
// Expected grant vectors are queued when source edges are driven and popped when irq_req rises.
module tb_timer_irq_scheduler;

  localparam int NUM_CH    = 4;
  localparam int VEC_WIDTH = 4;
  localparam int NSRC      = 3 * NUM_CH;

  logic                  clk;
  logic                  rst;
  logic [NUM_CH-1:0]     cmia;
  logic [NUM_CH-1:0]     cmib;
  logic [NUM_CH-1:0]     ovi;
  logic [NSRC-1:0]       irqEn;
  logic                  clrValid;
  logic [VEC_WIDTH-1:0]  clrIdx;
  logic [NSRC-1:0]       pend;

  int compareCount  = 0;
  int mismatchCount = 0;
  int expVecQ[$];

  timer_irq_scheduler_if #(.VEC_WIDTH(VEC_WIDTH)) irqIf ();

  timer_irq_scheduler #(
    .NUM_CH    (NUM_CH),
    .VEC_WIDTH (VEC_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmia      (cmia),
    .i_cmib      (cmib),
    .i_ovi       (ovi),
    .i_irq_en    (irqEn),
    .i_clr_valid (clrValid),
    .i_clr_idx   (clrIdx),
    .o_pend      (pend),
    .irqIf       (irqIf)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs are driven.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Scoreboard monitor: every new request must match the oldest queued expectation.
  initial begin
    logic prevReq;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (irqIf.irq_req && !prevReq) begin
        if (expVecQ.size() == 0) begin
          checkOutput("sbUnexpectedReq", 32'(irqIf.irq_vec), 32'hFFFF_FFFF);
        end else begin
          checkOutput("sbGrantVec", 32'(irqIf.irq_vec), 32'(expVecQ.pop_front()));
        end
      end
      prevReq = irqIf.irq_req;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    cmia          = '0;
    cmib          = '0;
    ovi           = '0;
    irqEn         = '0;
    clrValid      = 1'b0;
    clrIdx        = '0;
    irqIf.irq_ack = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("rstPend", 32'(pend), 32'h0);
    checkOutput("rstReq", 32'(irqIf.irq_req), 32'h0);
    checkOutput("rstVec", 32'(irqIf.irq_vec), 32'h0);
    rst   = 1'b0;
    irqEn = '1;
    applyStimulus(1);

    // Single edge on OVI channel 1 (index 5)
    ovi[1] = 1'b1;
    expVecQ.push_back(5);
    applyStimulus(1);
    checkOutput("s1PendSet", 32'(pend), 32'h020);
    checkOutput("s1ReqLow", 32'(irqIf.irq_req), 32'h0);
    ovi[1] = 1'b0;
    applyStimulus(1);
    checkOutput("s1Req", 32'(irqIf.irq_req), 32'h1);
    checkOutput("s1Vec", 32'(irqIf.irq_vec), 32'h5);
    applyStimulus(3);
    checkOutput("s1ReqHeld", 32'(irqIf.irq_req), 32'h1);
    checkOutput("s1VecHeld", 32'(irqIf.irq_vec), 32'h5);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    checkOutput("s1AckReq", 32'(irqIf.irq_req), 32'h0);
    checkOutput("s1AckPend", 32'(pend), 32'h0);
    applyStimulus(2);
    checkOutput("s1IdleReq", 32'(irqIf.irq_req), 32'h0);

    // Priority without preemption: index 7 first, then index 0 arrives
    cmib[2] = 1'b1;
    expVecQ.push_back(7);
    applyStimulus(2);
    checkOutput("s2Vec7", 32'(irqIf.irq_vec), 32'h7);
    cmia[0] = 1'b1;
    expVecQ.push_back(0);
    applyStimulus(1);
    checkOutput("s2PendBoth", 32'(pend), 32'h081);
    applyStimulus(1);
    checkOutput("s2NoPreempt", 32'(irqIf.irq_vec), 32'h7);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    checkOutput("s2AckReq", 32'(irqIf.irq_req), 32'h0);
    applyStimulus(1);
    checkOutput("s2GapReq", 32'(irqIf.irq_req), 32'h0);
    applyStimulus(1);
    checkOutput("s2SecondReq", 32'(irqIf.irq_req), 32'h1);
    checkOutput("s2SecondVec", 32'(irqIf.irq_vec), 32'h0);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    cmia[0] = 1'b0;
    cmib[2] = 1'b0;
    checkOutput("s2PendClear", 32'(pend), 32'h0);
    applyStimulus(2);

    // Enable gating on index 9
    irqEn   = '0;
    cmia[3] = 1'b1;
    expVecQ.push_back(9);
    applyStimulus(1);
    cmia[3] = 1'b0;
    checkOutput("s3Pend9", 32'(pend), 32'h200);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      checkOutput("s3GatedReq", 32'(irqIf.irq_req), 32'h0);
    end
    irqEn = 12'h200;
    applyStimulus(1);
    checkOutput("s3EnReq", 32'(irqIf.irq_req), 32'h1);
    checkOutput("s3EnVec", 32'(irqIf.irq_vec), 32'h9);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    checkOutput("s3PendClear", 32'(pend), 32'h0);
    irqEn = '1;
    applyStimulus(2);

    // Set beats clear on index 4
    cmib[1] = 1'b1;
    expVecQ.push_back(4);
    applyStimulus(1);
    cmib[1] = 1'b0;
    applyStimulus(1);
    checkOutput("s4Vec4", 32'(irqIf.irq_vec), 32'h4);
    irqIf.irq_ack = 1'b1;
    cmib[1]       = 1'b1;
    expVecQ.push_back(4);
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    cmib[1]       = 1'b0;
    checkOutput("s4PendKept", 32'(pend), 32'h010);
    checkOutput("s4AckReq", 32'(irqIf.irq_req), 32'h0);
    applyStimulus(2);
    checkOutput("s4ReReq", 32'(irqIf.irq_req), 32'h1);
    checkOutput("s4ReVec", 32'(irqIf.irq_vec), 32'h4);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    checkOutput("s4PendClear", 32'(pend), 32'h0);
    applyStimulus(2);

    // Software clear, out-of-range clear, and level-held source
    irqEn  = 12'hFFB;
    ovi[0] = 1'b1;
    applyStimulus(1);
    ovi[0] = 1'b0;
    checkOutput("s5Pend2", 32'(pend), 32'h004);
    applyStimulus(1);
    checkOutput("s5DisabledReq", 32'(irqIf.irq_req), 32'h0);
    clrValid = 1'b1;
    clrIdx   = 4'd2;
    applyStimulus(1);
    clrValid = 1'b0;
    checkOutput("s5SwClear", 32'(pend), 32'h0);
    ovi[0] = 1'b1;
    applyStimulus(1);
    ovi[0]   = 1'b0;
    clrValid = 1'b1;
    clrIdx   = 4'd13;
    applyStimulus(1);
    clrValid = 1'b0;
    checkOutput("s5BadIdxIgnored", 32'(pend), 32'h004);
    clrValid = 1'b1;
    clrIdx   = 4'd2;
    applyStimulus(1);
    clrValid = 1'b0;
    irqEn  = '0;
    ovi[3] = 1'b1;
    applyStimulus(1);
    checkOutput("s5LevelSet", 32'(pend), 32'h800);
    clrValid = 1'b1;
    clrIdx   = 4'd11;
    applyStimulus(1);
    clrValid = 1'b0;
    for (int c = 0; c < 18; c++) begin
      applyStimulus(1);
      checkOutput("s5LevelNoReset", 32'(pend), 32'h0);
    end
    ovi[3] = 1'b0;
    irqEn  = '1;
    applyStimulus(2);

    // Reset while a request is outstanding
    cmia[1] = 1'b1;
    ovi[1]  = 1'b1;
    cmib[2] = 1'b1;
    expVecQ.push_back(3);
    applyStimulus(1);
    cmia[1] = 1'b0;
    ovi[1]  = 1'b0;
    cmib[2] = 1'b0;
    checkOutput("s6Pend0A8", 32'(pend), 32'h0A8);
    applyStimulus(1);
    checkOutput("s6Vec3", 32'(irqIf.irq_vec), 32'h3);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("s6RstReq", 32'(irqIf.irq_req), 32'h0);
    checkOutput("s6RstVec", 32'(irqIf.irq_vec), 32'h0);
    checkOutput("s6RstPend", 32'(pend), 32'h0);
    irqIf.irq_ack = 1'b1;
    applyStimulus(1);
    irqIf.irq_ack = 1'b0;
    checkOutput("s6AckIgnoredReq", 32'(irqIf.irq_req), 32'h0);
    checkOutput("s6AckIgnoredPend", 32'(pend), 32'h0);
    applyStimulus(3);
    checkOutput("s6StayIdle", 32'(irqIf.irq_req), 32'h0);

    checkOutput("sbDrained", 32'(expVecQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/timer_irq_scheduler.md
Name: timer_irq_scheduler

Overview:
Collects the 12 timer interrupt sources from both timer units: CMIA, CMIB and OVI for channels 0-3. Each rising edge is latched into a pending bit. The block grants one source at a time to the CPU interrupt interface through a fixed-priority req/ack handshake, and pending bits are cleared on acknowledge or by a software clear strobe. It sits between the two timer units and the CPU interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels; source count = 3*NUM_CH.
VEC_WIDTH, 4, width of source index / vector; must satisfy 2^VEC_WIDTH >= 3*NUM_CH.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmia  input  NUM_CH  compare-match-A level per channel (bit n = channel n)
cmib  input  NUM_CH  compare-match-B level per channel
ovi  input  NUM_CH  overflow level per channel
irq_en  input  3*NUM_CH  per-source enable, bit i = source i
clr_valid  input  1  software clear strobe, one cycle
clr_idx  input  VEC_WIDTH  source index to clear when clr_valid=1
irq_ack  input  1  CPU acknowledge of current request
irq_req  output  1  interrupt request to CPU
irq_vec  output  VEC_WIDTH  index of requested source, valid while irq_req=1
pend  output  3*NUM_CH  pending flags, registered

Behaviour:
- Interface (already decided): one clock, clk; reset is rst, synchronous and active-high.
- Source index i = 3*ch + k, with k=0 CMIA, k=1 CMIB, k=2 OVI. Channel 0 CMIA is index 0.
- Priority is fixed: the lowest index wins.
- Reset: pend=0, irq_req=0, irq_vec=0, all edge-detect history regs=0, FSM=IDLE. A source held high at reset release is seen as a rising edge on the first cycle after reset.
- Edge detect: at each clk, a rising edge on source i exists when the sampled level is 1 and the previous sample is 0. The pend bit sets at that clk edge. Level-held sources do not re-set pend.
- pend sets regardless of irq_en; irq_en only gates arbitration.
- Set beats clear: if a new edge on source i coincides with an ack-clear or clr_valid on i in the same cycle, pend[i] ends at 1.
- clr_valid with clr_idx >= 3*NUM_CH is ignored.
- Latency: source goes high before clk edge k, so pend is visible after edge k and irq_req is visible after edge k+1, provided the FSM is IDLE.
- FSM states:
  - IDLE: irq_req=0. If (pend & irq_en) != 0, latch irq_vec = lowest set index and go to REQ. Otherwise stay.
  - REQ: irq_req=1 and irq_vec is held stable.
    - The request is not withdrawn if irq_en[irq_vec] drops or pend[irq_vec] is cleared by clr_valid; it is held until ack.
    - A higher-priority source arriving during REQ does not preempt.
    - On irq_ack=1: clear pend[irq_vec] (subject to set-beats-clear), deassert irq_req on the next edge, go to GAP.
  - GAP: irq_req=0 for exactly one cycle, then go to IDLE. This guarantees a minimum one-cycle low between requests.
- irq_ack while in IDLE or GAP is ignored.
- Back-to-back service: with two sources pending, the second irq_req rises 2 cycles after the ack edge (REQ->GAP, GAP->IDLE, IDLE->REQ).
- irq_req, irq_vec and pend are all registered outputs; there is no combinational input-to-output path.
- rst asserted mid-request: on the next edge irq_req drops to 0, pend clears and all pending events are lost.

Test Plan:
- Reset, then single edge: irq_en=all 1s, pulse ovi[1] high for 1 cycle -> pend[5]=1 after 1 edge; irq_req=1, irq_vec=5 after 2 edges; hold; irq_ack for 1 cycle -> pend[5]=0, irq_req=0, returns to IDLE.
- Priority and no preemption: raise cmib[2] (index 7) and wait for irq_req with vec=7; then raise cmia[0] (index 0) -> irq_vec stays 7 until ack; after ack, 1 GAP cycle, then irq_req=1 with vec=0 exactly 2 cycles after the ack edge.
- Enable gating: irq_en=0, pulse cmia[3] -> pend[9]=1, irq_req stays 0 for 10 cycles; set irq_en[9]=1 -> irq_req=1, vec=9 on the following edge+1.
- Set-beats-clear: while vec=4 is requested, drive a new cmib[1] rising edge in the same cycle as irq_ack -> pend[4] remains 1; the next request after GAP is vec=4 again.
- Software clear and ignored index: pend[2]=1 with irq_en[2]=0; clr_valid with clr_idx=2 -> pend[2]=0. clr_valid with clr_idx=13 -> pend unchanged. A level held high for 20 cycles -> exactly one pend set.
- Reset mid-operation: irq_req=1 with vec=3 and pend=12'h0A8; assert rst for 1 cycle -> after the edge irq_req=0, irq_vec=0, pend=0; irq_ack in the following cycle has no effect.
